// File: rtl/rpi_irq_arbiter.sv
// rpi_irq_arbiter: round-robin interrupt arbiter that gates the Raspberry Pi interrupt clock generator
// Ports: clk_in system clock; rst_n async active-low reset; req_in per-source event pulses;
//   rpi_ack async acknowledge level from the Pi (rising edge acks); clr_overrun clears overrun flags;
//   irq_enable registered generator enable; irq_src source being serviced; busy high outside IDLE;
//   pending/overrun per-source event and lost-event flags; timeout_err one-cycle abandon pulse.
module rpi_irq_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MIN_ON  = 64,
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_in,
    input  logic                     rpi_ack,
    input  logic                     clr_overrun,
    output logic                     irq_enable,
    output logic [$clog2(N_REQ)-1:0] irq_src,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending,
    output logic [N_REQ-1:0]         overrun,
    output logic                     timeout_err
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = $clog2(MIN_ON > GAP ? MIN_ON : GAP) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ASSERT, S_WAIT_ACK, S_GAP} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tcnt;
    logic [SW-1:0]    last_grant, grant;
    logic             ack_s1, ack_s2, ack_d, ack_seen;
    logic             ack_rise, assert_end, done, timed_out, found;
    logic [N_REQ-1:0] complete;
    assign ack_rise   = ack_s2 & ~ack_d;
    assign assert_end = state == S_ASSERT && cnt == CW'(MIN_ON - 1);
    assign done       = (assert_end && (ack_seen || ack_rise)) || (state == S_WAIT_ACK && ack_rise);
    // an ack arriving on the timeout cycle still counts as an ack
    assign timed_out  = state == S_WAIT_ACK && !ack_rise && tcnt == TW'(TIMEOUT - 1);
    assign complete   = done ? N_REQ'(1) << irq_src : '0;
    assign busy       = state != S_IDLE;
    // first pending source after the last grant, wrapping
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++)
            if (!found && pending[(int'(last_grant) + k) % N_REQ]) begin
                grant = SW'((int'(last_grant) + k) % N_REQ);
                found = 1'b1;
            end
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            ack_s1      <= 1'b0;
            ack_s2      <= 1'b0;
            ack_d       <= 1'b0;
            ack_seen    <= 1'b0;
            irq_enable  <= 1'b0;
            irq_src     <= '0;
            last_grant  <= SW'(N_REQ - 1);
            pending     <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack_s1      <= rpi_ack;
            ack_s2      <= ack_s1;
            ack_d       <= ack_s2;
            // a new event on the completing source re-arms it rather than overrunning
            pending     <= (pending & ~complete) | req_in;
            overrun     <= (clr_overrun ? '0 : overrun) | (req_in & pending & ~complete);
            timeout_err <= timed_out;
            case (state)
                S_IDLE: if (|pending) state <= S_ARB;
                S_ARB: begin
                    irq_src    <= grant;
                    last_grant <= grant;
                    cnt        <= '0;
                    tcnt       <= '0;
                    ack_seen   <= 1'b0;
                    irq_enable <= 1'b1;
                    state      <= S_ASSERT;
                end
                S_ASSERT: begin
                    tcnt     <= tcnt + 1'b1;
                    ack_seen <= ack_seen | ack_rise;
                    cnt      <= assert_end ? '0 : cnt + 1'b1;
                    if (assert_end) begin
                        state      <= done ? S_GAP : S_WAIT_ACK;
                        irq_enable <= !done;
                    end
                end
                S_WAIT_ACK: begin
                    tcnt <= tcnt + 1'b1;
                    if (done || timed_out) begin
                        state      <= S_GAP;
                        irq_enable <= 1'b0;
                    end
                end
                S_GAP: begin
                    cnt <= cnt == CW'(GAP - 1) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(GAP - 1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rpi_irq_arbiter.sv
// tb_rpi_irq_arbiter: timeline-model checker plus directed and random stimulus for rpi_irq_arbiter
module tb_rpi_irq_arbiter;
    localparam int N = 4, MIN_ON = 64, TIMEOUT = 4096, GAP = 32;
    logic         clk_in = 1'b0, rst_n = 1'b0, rpi_ack = 1'b0, clr_overrun = 1'b0;
    logic [N-1:0] req_in = '0;
    logic         irq_enable, busy, timeout_err;
    logic [1:0]   irq_src;
    logic [N-1:0] pending, overrun;
    int           checks = 0, errors = 0;
    bit           started = 1'b0;
    logic [N-1:0] rnd;
    int           src;

    rpi_irq_arbiter #(.N_REQ(N), .MIN_ON(MIN_ON), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req_in(req_in), .rpi_ack(rpi_ack),
        .clr_overrun(clr_overrun), .irq_enable(irq_enable), .irq_src(irq_src), .busy(busy),
        .pending(pending), .overrun(overrun), .timeout_err(timeout_err));

    always #10 clk_in = ~clk_in;

    // Model: edge counter plus timestamps of the current interrupt (enable rise, completion)
    int           cyc, t_rise, t_end, m_src, m_last;
    bit           m_busy, m_ackd, m_to, h0, h1, h2, m_ar;
    logic [N-1:0] m_pend, m_ovr, m_comp;

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return last;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; t_rise = -1; t_end = -1; m_src = 0; m_last = N - 1;
            m_busy = 0; m_ackd = 0; m_to = 0; h0 = 0; h1 = 0; h2 = 0;
            m_pend = '0; m_ovr = '0;
        end else begin
            // pin level seen two edges ago vs three edges ago: a rise acts on the third edge
            m_ar = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = rpi_ack;
            cyc++;
            m_comp = '0;
            m_to = 0;
            if (!m_busy) begin
                if (|m_pend) begin m_busy = 1; t_rise = -1; t_end = -1; end
            end else if (t_rise < 0) begin
                m_src = rr_pick(m_pend, m_last); m_last = m_src; t_rise = cyc; m_ackd = 0;
            end else if (t_end < 0) begin
                m_ackd |= m_ar;
                if (m_ackd && cyc - t_rise >= MIN_ON) begin t_end = cyc; m_comp[m_src] = 1'b1; end
                else if (cyc - t_rise == TIMEOUT) begin t_end = cyc; m_to = 1; end
            end else if (cyc - t_end == GAP) m_busy = 0;
            m_ovr  = (clr_overrun ? '0 : m_ovr) | (req_in & m_pend & ~m_comp);
            m_pend = (m_pend & ~m_comp) | req_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) if (started && rst_n) begin
        chk("m_irq_enable", 32'(irq_enable), 32'(m_busy && t_rise >= 0 && t_end < 0));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_irq_src", 32'(irq_src), 32'(m_src));
        chk("m_pending", 32'(pending), 32'(m_pend));
        chk("m_overrun", 32'(overrun), 32'(m_ovr));
        chk("m_timeout_err", 32'(timeout_err), 32'(m_to));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_in = '0; rpi_ack = 1'b0; clr_overrun = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_en(input logic lvl, input string nm);
        int n = 0;
        while (irq_enable !== lvl && n < 6000) begin tick(1); n++; end
        chk(nm, 32'(irq_enable), 32'(lvl));
    endtask

    task automatic service_one(output int s);
        wait_en(1'b1, "svc_rise");
        s = int'(irq_src);
        tick(70);
        rpi_ack = 1'b1;
        tick(3);
        rpi_ack = 1'b0;
        wait_en(1'b0, "svc_fall");
    endtask

    initial begin
        do_reset();
        started = 1'b1;
        chk("rst_enable", 32'(irq_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_src", 32'(irq_src), 0);
        // single req_in[2], ack in WAIT_ACK
        req_in = 4'b0100; tick(1); req_in = '0;
        chk("t1_pending", 32'(pending), 32'h4);
        tick(1);
        chk("t1_arb_busy", 32'(busy), 1);
        chk("t1_arb_en", 32'(irq_enable), 0);
        tick(1);
        chk("t1_en_rise", 32'(irq_enable), 1);
        chk("t1_src", 32'(irq_src), 2);
        tick(84);
        rpi_ack = 1'b1;
        tick(2);
        chk("t1_pend_hold", 32'(pending), 32'h4);
        tick(1);
        chk("t1_pend_clr", 32'(pending), 0);
        chk("t1_en_fall", 32'(irq_enable), 0);
        rpi_ack = 1'b0;
        tick(31);
        chk("t1_gap_busy", 32'(busy), 1);
        tick(1);
        chk("t1_idle", 32'(busy), 0);
        // ack during cycle 20 of ASSERT: exactly MIN_ON cycles high
        req_in = 4'b0001; tick(1); req_in = '0;
        tick(2);
        chk("t2_src", 32'(irq_src), 0);
        tick(17);
        rpi_ack = 1'b1;
        tick(46);
        chk("t2_en_63", 32'(irq_enable), 1);
        chk("t2_pend_63", 32'(pending), 32'h1);
        tick(1);
        chk("t2_en_64", 32'(irq_enable), 0);
        chk("t2_pend_64", 32'(pending), 0);
        rpi_ack = 1'b0;
        tick(32);
        chk("t2_idle", 32'(busy), 0);
        // no ack: timeout, pending kept, re-serviced after GAP
        req_in = 4'b0010; tick(1); req_in = '0;
        tick(2);
        chk("t3_src", 32'(irq_src), 1);
        tick(TIMEOUT - 1);
        chk("t3_pre_to", 32'(timeout_err), 0);
        chk("t3_pre_en", 32'(irq_enable), 1);
        tick(1);
        chk("t3_to", 32'(timeout_err), 1);
        chk("t3_en_off", 32'(irq_enable), 0);
        chk("t3_pend_kept", 32'(pending), 32'h2);
        tick(1);
        chk("t3_to_pulse", 32'(timeout_err), 0);
        tick(31);
        chk("t3_idle", 32'(busy), 0);
        tick(2);
        chk("t3_reservice", 32'(irq_enable), 1);
        chk("t3_resrc", 32'(irq_src), 1);
        tick(70); rpi_ack = 1'b1; tick(3); rpi_ack = 1'b0;
        chk("t3_done", 32'(pending), 0);
        // round-robin order from reset
        do_reset();
        req_in = 4'b1111; tick(1); req_in = '0;
        for (int i = 0; i < 4; i++) begin
            service_one(src);
            chk("t4_order", 32'(src), 32'(i));
        end
        req_in = 4'b1001; tick(1); req_in = '0;
        service_one(src);
        chk("t4_order_a", 32'(src), 0);
        service_one(src);
        chk("t4_order_b", 32'(src), 3);
        // overrun set/hold/clear and coincident completion
        do_reset();
        req_in = 4'b0010; tick(1);
        tick(1);
        chk("t5_ovr_set", 32'(overrun), 32'h2);
        clr_overrun = 1'b1; tick(1);
        chk("t5_set_wins", 32'(overrun), 32'h2);
        req_in = '0; tick(1);
        chk("t5_cleared", 32'(overrun), 0);
        clr_overrun = 1'b0;
        tick(80);
        rpi_ack = 1'b1;
        tick(2);
        req_in = 4'b0010; tick(1); req_in = '0; rpi_ack = 1'b0;
        chk("t5_co_pend", 32'(pending), 32'h2);
        chk("t5_co_ovr", 32'(overrun), 0);
        chk("t5_co_en", 32'(irq_enable), 0);
        service_one(src);
        chk("t5_resrc", 32'(src), 1);
        // async reset in WAIT_ACK
        tick(40);
        req_in = 4'b1000; tick(1); req_in = '0;
        tick(80);
        chk("t6_in_wait", 32'(irq_enable), 1);
        #4 rst_n = 1'b0;
        #1;
        chk("t6_en", 32'(irq_enable), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pend", 32'(pending), 0);
        chk("t6_src", 32'(irq_src), 0);
        chk("t6_to", 32'(timeout_err), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        // random traffic; middle stretch holds the pin to force timeouts
        for (int c = 0; c < 20000; c++) begin
            for (int b = 0; b < N; b++) rnd[b] = ($urandom_range(47) == 0);
            req_in = rnd;
            if ((c / 5000) % 2 == 0 && $urandom_range(29) == 0) rpi_ack = ~rpi_ack;
            clr_overrun = ($urandom_range(199) == 0);
            tick(1);
        end
        req_in = '0; clr_overrun = 1'b0;
        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
